cache_cmd_arbiter: RTL

Shares the single command port of the cache model (4-bit command n, 32-bit address) among three requesters: instruction fetch, data read/write, and maintenance (clear, print).
- Arbitrates among them and holds one pending command in an output slot under cache backpressure.
- Enforces a quiet window after a cache clear.
- Keeps per-type transfer counters.
- Sits between the trace/CPU-side requesters and the cache top level.

---
 rtl/cache_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 30 +++
 rtl/cache_cmd_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache command path: command codes, arbiter FSM states and
// requester identifiers.
package cache_pkg;

    localparam logic [3:0] CMD_READ   = 4'd0;
    localparam logic [3:0] CMD_WRITE  = 4'd1;
    localparam logic [3:0] CMD_IFETCH = 4'd2;
    localparam logic [3:0] CMD_CLEAR  = 4'd8;
    localparam logic [3:0] CMD_PRINT  = 4'd9;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StFlush
    } state_e;

    typedef enum logic [1:0] {
        ReqNone,
        ReqI,
        ReqD,
        ReqM
    } req_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the requester just granted becomes lowest priority.
module rr_arb2 (
    input  logic clk,
    input  logic clear,
    input  logic en_i,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    // Set when requester 1 should win the next tie.
    logic prio1_q;

    always_comb begin
        gnt0_o = en_i && req0_i && (!req1_i || !prio1_q);
        gnt1_o = en_i && req1_i && (!req0_i || prio1_q);
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            prio1_q <= 1'b0;
        end else if (gnt0_o) begin
            prio1_q <= 1'b1;
        end else if (gnt1_o) begin
            prio1_q <= 1'b0;
        end
    end

endmodule

// File: rtl/cache_cmd_arbiter.sv
// Shares the cache command port among fetch, data and maintenance requesters with a
// one-entry output slot, a post-clear quiet window and per-type transfer counters.
module cache_cmd_arbiter
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned CMD_W        = 4,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned FLUSH_CYCLES = 4
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    input  logic              m_req,
    input  logic [CMD_W-1:0]  m_cmd,
    output logic              m_gnt,
    output logic              c_valid,
    output logic [CMD_W-1:0]  c_cmd,
    output logic [ADDR_W-1:0] c_addr,
    input  logic              c_busy,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  if_count,
    output logic              err
);

    localparam int unsigned FlW = $clog2(FLUSH_CYCLES + 1);

    state_e            state_q, state_d;
    logic [FlW-1:0]    flush_q, flush_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rd_q, rd_d, wr_q, wr_d, if_q, if_d;

    logic xfer, clr_xfer, grant_en, m_legal, arb_i_gnt, arb_d_gnt;
    req_e winner;

    always_comb begin
        xfer     = (state_q == StHold) && !c_busy;
        clr_xfer = xfer && (cmd_q == CMD_W'(CMD_CLEAR));
        // Grants are also masked during reset so every output reads 0 while clear is high.
        grant_en = !clear && ((state_q == StIdle) || xfer) && !clr_xfer;
        m_legal  = (m_cmd == CMD_W'(CMD_CLEAR)) || (m_cmd == CMD_W'(CMD_PRINT));
    end

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .clear  (clear),
        .en_i   (grant_en && !m_req),
        .req0_i (i_req),
        .req1_i (d_req),
        .gnt0_o (arb_i_gnt),
        .gnt1_o (arb_d_gnt)
    );

    always_comb begin
        i_gnt = arb_i_gnt;
        d_gnt = arb_d_gnt;
        m_gnt = grant_en && m_req;
        err   = m_gnt && !m_legal;

        winner = ReqNone;
        if (m_gnt && m_legal) begin
            winner = ReqM;
        end else if (arb_i_gnt) begin
            winner = ReqI;
        end else if (arb_d_gnt) begin
            winner = ReqD;
        end
    end

    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        if_d    = if_q;

        if (xfer) begin
            if (cmd_q == CMD_W'(CMD_READ)) begin
                rd_d = rd_q + CNT_W'(1);
            end else if (cmd_q == CMD_W'(CMD_WRITE)) begin
                wr_d = wr_q + CNT_W'(1);
            end else if (cmd_q == CMD_W'(CMD_IFETCH)) begin
                if_d = if_q + CNT_W'(1);
            end else if (cmd_q == CMD_W'(CMD_CLEAR)) begin
                rd_d = '0;
                wr_d = '0;
                if_d = '0;
            end
        end

        unique case (winner)
            ReqI: begin
                cmd_d  = CMD_W'(CMD_IFETCH);
                addr_d = i_addr;
            end
            ReqD: begin
                cmd_d  = d_wr ? CMD_W'(CMD_WRITE) : CMD_W'(CMD_READ);
                addr_d = d_addr;
            end
            ReqM: begin
                cmd_d  = m_cmd;
                addr_d = '0;
            end
            default: ;
        endcase

        case (state_q)
            StIdle: begin
                if (winner != ReqNone) state_d = StHold;
            end
            StHold: begin
                if (clr_xfer) begin
                    state_d = StFlush;
                    flush_d = FlW'(FLUSH_CYCLES);
                end else if (xfer) begin
                    state_d = (winner != ReqNone) ? StHold : StIdle;
                end
            end
            StFlush: begin
                flush_d = flush_q - FlW'(1);
                if (flush_q == FlW'(1)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= StIdle;
            flush_q <= '0;
            cmd_q   <= '0;
            addr_q  <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            if_q    <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            if_q    <= if_d;
        end
    end

    assign c_valid  = (state_q == StHold);
    assign c_cmd    = cmd_q;
    assign c_addr   = addr_q;
    assign rd_count = rd_q;
    assign wr_count = wr_q;
    assign if_count = if_q;

endmodule
